// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for RV32M, one step per cycle.
// Optional MULDIV_FASTPATH_EN short-circuits trivial divides and zero multiplies.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [CNT_W-1:0]   r_cnt;
  logic               r_init;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_result;

  logic               w_accept;
  logic               w_last;
  logic               w_is_div;
  logic               w_sa;
  logic               w_sb;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;
  logic [WIDTH-1:0]   w_final;
  logic               w_fast;
  logic [WIDTH-1:0]   w_fast_res;

  assign in_ready  = rstn && (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign result    = r_result;

  assign w_accept = in_valid && in_ready && !flush;
  assign w_last   = !r_init && (r_cnt == CNT_W'(1));
  assign w_is_div = r_op[2];

  assign w_sa    = w_is_div ? !r_op[0] : (r_op[1:0] != 2'b11);
  assign w_sb    = w_is_div ? !r_op[0] : !r_op[1];
  assign w_neg_a = w_sa && r_a[WIDTH-1];
  assign w_neg_b = w_sb && r_b[WIDTH-1];
  assign w_mag_a = w_neg_a ? -r_a : r_a;
  assign w_mag_b = w_neg_b ? -r_b : r_b;

  // After the setup cycle r_b holds the multiplicand/divisor magnitude
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_trial   = w_rem_sh - {1'b0, r_b};

  always_comb begin
    w_step = {w_mul_sum, r_acc[WIDTH-1:1]};
    if (w_is_div) begin
      if (w_trial[WIDTH])
        w_step = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
      else
        w_step = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end
  end

  assign w_prod = r_neg_q ? -w_step : w_step;
  assign w_q    = w_step[WIDTH-1:0];
  assign w_r    = w_step[2*WIDTH-1:WIDTH];

  // Divide by zero must yield all ones regardless of the dividend sign
  always_comb begin
    w_final = '0;
    unique case (1'b1)
      !r_op[2] && (r_op[1:0] == 2'b00): w_final = w_prod[WIDTH-1:0];
      !r_op[2] && (r_op[1:0] != 2'b00): w_final = w_prod[2*WIDTH-1:WIDTH];
      r_op[2] && !r_op[1]:
        w_final = (r_b == '0) ? '1 : (r_neg_q ? -w_q : w_q);
      r_op[2] && r_op[1]: w_final = r_neg_r ? -w_r : w_r;
      default: w_final = '0;
    endcase
  end

`ifdef MULDIV_FASTPATH_EN
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  logic w_ovf;
  assign w_ovf  = r_op[2] && !r_op[0] && (r_a == MIN_NEG) && (&r_b);
  assign w_fast = r_op[2] ? ((r_b == '0) || w_ovf)
                          : ((r_a == '0) || (r_b == '0));
  always_comb begin
    w_fast_res = '0;
    if (r_op[2]) begin
      if (r_b == '0)
        w_fast_res = r_op[1] ? r_a : '1;
      else
        w_fast_res = r_op[1] ? '0 : r_a;
    end
  end
`else
  assign w_fast     = 1'b0;
  assign w_fast_res = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next_state = S_CALC;
      S_CALC: if ((r_init && w_fast) || w_last) w_next_state = S_DONE;
      S_DONE: if (out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    if (flush) w_next_state = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt    <= '0;
      r_init   <= 1'b0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op   <= op;
      r_a    <= a;
      r_b    <= b;
      r_cnt  <= CNT_W'(WIDTH);
      r_init <= 1'b1;
    end else if (r_state == S_CALC && !flush) begin
      if (r_init) begin
        r_init  <= 1'b0;
        r_acc   <= {{WIDTH{1'b0}}, w_mag_a};
        r_b     <= w_mag_b;
        r_neg_q <= w_neg_a ^ w_neg_b;
        r_neg_r <= w_neg_a;
        if (w_fast) r_result <= w_fast_res;
      end else begin
        r_acc <= w_step;
        r_cnt <= r_cnt - CNT_W'(1);
        if (w_last) r_result <= w_final;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32 and WIDTH=8.
// Checks results, latency, backpressure, flush and mid-operation reset.
module tb_muldiv_unit;

`ifdef MULDIV_FASTPATH_EN
  localparam int FAST32 = 1;
  localparam int FAST8  = 1;
`else
  localparam int FAST32 = 33;
  localparam int FAST8  = 9;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        busy;

  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [2:0]  op8 = '0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        out_valid8;
  logic        out_ready8 = 1'b0;
  logic [7:0]  result8;
  logic        busy8;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) u32 (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  muldiv_unit #(.WIDTH(8)) u8 (
    .clk(clk), .rstn(rstn), .flush(1'b0),
    .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .busy(busy8)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run32(input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input bit hs,
                       output logic [31:0] res, output int lat);
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    if (hs) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic run8(input logic [2:0] o, input logic [7:0] x,
                      input logic [7:0] y,
                      output logic [7:0] res, output int lat);
    @(posedge clk); #1;
    in_valid8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result8;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  r8;
    int          lat;
    bit          seen;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", in_ready, 1);

    run32(3'b000, 32'hFFFF_FFFE, 32'd3, 1'b1, r, lat);
    chk("mul", r, 32'hFFFF_FFFA);
    chk("mul_lat", lat, 33);
    run32(3'b001, 32'hFFFF_FFFE, 32'd3, 1'b1, r, lat);
    chk("mulh", r, 32'hFFFF_FFFF);
    run32(3'b011, 32'hFFFF_FFFE, 32'd3, 1'b1, r, lat);
    chk("mulhu", r, 32'h0000_0002);

    run32(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b1, r, lat);
    chk("div", r, 32'hFFFF_FFFD);
    chk("div_lat", lat, 33);
    run32(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b1, r, lat);
    chk("rem", r, 32'hFFFF_FFFF);
    run32(3'b101, 32'd7, 32'd2, 1'b1, r, lat);
    chk("divu", r, 32'd3);
    run32(3'b111, 32'd7, 32'd2, 1'b1, r, lat);
    chk("remu", r, 32'd1);

    run32(3'b100, 32'h1234_5678, 32'd0, 1'b1, r, lat);
    chk("div0", r, 32'hFFFF_FFFF);
    chk("div0_lat", lat, FAST32);
    run32(3'b110, 32'h1234_5678, 32'd0, 1'b1, r, lat);
    chk("rem0", r, 32'h1234_5678);
    run32(3'b101, 32'h8765_4321, 32'd0, 1'b1, r, lat);
    chk("divu0", r, 32'hFFFF_FFFF);
    run32(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, r, lat);
    chk("div_ovf", r, 32'h8000_0000);
    chk("ovf_lat", lat, FAST32);
    run32(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, r, lat);
    chk("rem_ovf", r, 32'd0);

    run32(3'b000, 32'd5, 32'd7, 1'b0, r, lat);
    chk("bp_res", r, 32'd35);
    seen = 1'b0;
    in_valid = 1'b1; op = 3'b101; a = 32'd9; b = 32'd3;
    repeat (10) begin
      @(posedge clk); #1;
      if (result !== 32'd35 || in_ready !== 1'b0 || busy !== 1'b1
          || out_valid !== 1'b1)
        seen = 1'b1;
    end
    in_valid = 1'b0;
    chk("bp_hold", seen, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_hs_valid", out_valid, 0);
    chk("bp_hs_ready", in_ready, 1);

    in_valid = 1'b1; op = 3'b101; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl_busy", busy, 0);
    chk("fl_ready", in_ready, 1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("fl_no_valid", seen, 0);
    chk("fl_result", result, 32'd35);

    run32(3'b000, 32'd6, 32'd7, 1'b0, r, lat);
    chk("fd_res", r, 32'd42);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    chk("fd_valid", out_valid, 0);
    chk("fd_result", result, 32'd42);

    flush = 1'b1; in_valid = 1'b1; op = 3'b000; a = 32'd2; b = 32'd2;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("fi_busy", busy, 0);

    in_valid = 1'b1; op = 3'b000; a = 32'd11; b = 32'd13;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("mr_valid", out_valid, 0);
    chk("mr_result", result, 0);
    chk("mr_ready", in_ready, 0);
    chk("mr_busy", busy, 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("mr_rel_ready", in_ready, 1);
    run32(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, r, lat);
    chk("mulhsu", r, 32'hFFFF_FFFF);
    chk("mulhsu_lat", lat, 33);

    run8(3'b011, 8'hFF, 8'hFF, r8, lat);
    chk("w8_mulhu", r8, 8'hFE);
    chk("w8_lat", lat, 9);
    run8(3'b100, 8'h80, 8'hFF, r8, lat);
    chk("w8_div_ovf", r8, 8'h80);
    chk("w8_ovf_lat", lat, FAST8);
    run8(3'b000, 8'hF6, 8'h0D, r8, lat);
    chk("w8_mul", r8, 8'h7E);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
